// File: rtl/hs_src_arbiter.sv
// Round-robin arbiter in front of the source port of a handshake CDC
// synchronizer. Picks one pending requester, issues its word with a one-cycle
// sready pulse, then follows sidle through the synchronizer round trip
// before arbitrating again.
module hs_src_arbiter #(
  parameter int N     = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N-1:0]               req,
  input  logic [N*WIDTH-1:0]         req_data,
  output logic [N-1:0]               grant,
  input  logic                       sidle,
  output logic                       sready,
  output logic [WIDTH-1:0]           din,
  output logic                       busy,
  output logic [$clog2(N)-1:0]       last_id,
  output logic [15:0]                xfer_cnt
);

  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {ARB, ISSUE, WAIT_LO, WAIT_HI} state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] sel;
  logic          found;
  logic [1:0]    lo_cnt;
  int            idx;

  // Round-robin pick: first set req bit after the pointer, wrapping modulo N.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = IW'(idx);
      end
    end
  end

  // Transfer FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ARB;
      ptr      <= IW'(N-1);
      lo_cnt   <= '0;
      grant    <= '0;
      sready   <= 1'b0;
      din      <= '0;
      busy     <= 1'b0;
      last_id  <= IW'(N-1);
      xfer_cnt <= '0;
    end else begin
      case (state)
        ARB: begin
          grant  <= '0;
          sready <= 1'b0;
          if (sidle && found) begin
            sready  <= 1'b1;
            din     <= req_data[sel*WIDTH +: WIDTH];
            grant   <= {{(N-1){1'b0}}, 1'b1} << sel;
            last_id <= sel;
            ptr     <= sel;
            busy    <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          // Synchronizer captures din on this edge; drop the pulses.
          sready <= 1'b0;
          grant  <= '0;
          lo_cnt <= '0;
          state  <= WAIT_LO;
        end
        WAIT_LO: begin
          // Lost-start guard: sidle never left idle, treat word as dropped.
          if (!sidle) begin
            state <= WAIT_HI;
          end else if (lo_cnt == 2'd3) begin
            busy  <= 1'b0;
            state <= ARB;
          end else begin
            lo_cnt <= lo_cnt + 2'd1;
          end
        end
        WAIT_HI: begin
          if (sidle) begin
            xfer_cnt <= xfer_cnt + 16'd1;
            busy     <= 1'b0;
            state    <= ARB;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= ARB;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hs_src_arbiter.sv
// Directed bench for hs_src_arbiter. Expected grants are queued when a request
// is raised and popped when the DUT issues sready; the bench plays the
// synchronizer by driving sidle.
module tb_hs_src_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   grant;
  logic           sidle;
  logic           sready;
  logic [W-1:0]   din;
  logic           busy;
  logic [1:0]     last_id;
  logic [15:0]    xfer_cnt;

  hs_src_arbiter #(.N(N), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .grant(grant),
    .sidle(sidle), .sready(sready), .din(din), .busy(busy),
    .last_id(last_id), .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [W-1:0] data;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [15:0] exp_cnt;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int id);
    exp_t e;
    e.id   = id;
    e.data = req_data[id*W +: W];
    sb.push_back(e);
  endtask

  // Wait for sready, compare against the scoreboard head, step into WAIT_LO.
  task automatic wait_issue(input bit hold);
    int   n;
    exp_t e;
    n = 0;
    while (sready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (sready !== 1'b1) begin
      chk("sready_timeout", 32'(sready), 32'd1);
      return;
    end
    if (sb.size() == 0) begin
      chk("sb_underflow", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("grant",   32'(grant),   32'(1 << e.id));
      chk("din",     32'(din),     32'(e.data));
      chk("last_id", 32'(last_id), 32'(e.id));
      chk("busy_issue", 32'(busy), 32'd1);
    end
    if (!hold) req = req & ~grant;
    tick();
    chk("sready_drop", 32'(sready), 32'd0);
    chk("grant_drop",  32'(grant),  32'd0);
  endtask

  // Synchronizer round trip: sidle low for lo cycles, then back high.
  task automatic complete(input int lo);
    int n;
    sidle = 1'b0;
    repeat (lo) begin
      tick();
      chk("sready_while_busy", 32'(sready), 32'd0);
    end
    sidle = 1'b1;
    n = 0;
    while (busy !== 1'b0 && n < 20) begin
      tick();
      n++;
    end
    exp_cnt = exp_cnt + 16'd1;
    chk("busy_done", 32'(busy),     32'd0);
    chk("xfer_cnt",  32'(xfer_cnt), 32'(exp_cnt));
  endtask

  initial begin
    rst_n    = 1'b0;
    req      = '0;
    sidle    = 1'b1;
    exp_cnt  = '0;
    for (int i = 0; i < N; i++) req_data[i*W +: W] = 8'(8'h11 * (i + 1));
    tick();
    tick();
    rst_n = 1'b1;

    // reset state
    chk("rst_grant",   32'(grant),    32'd0);
    chk("rst_sready",  32'(sready),   32'd0);
    chk("rst_din",     32'(din),      32'd0);
    chk("rst_busy",    32'(busy),     32'd0);
    chk("rst_last_id", 32'(last_id),  32'd3);
    chk("rst_xfer",    32'(xfer_cnt), 32'd0);

    // single request, one-cycle latency
    req_data[23:16] = 8'hA5;
    req = 4'b0100;
    push(2);
    tick();
    chk("single_latency", 32'(sready), 32'd1);
    wait_issue(1'b0);
    complete(2);

    // simultaneous requests held: 0,2,0,2
    req = 4'b0101;
    push(0); push(2); push(0); push(2);
    for (int t = 0; t < 4; t++) begin
      wait_issue(1'b1);
      complete(2);
    end
    req = '0;

    // reset during WAIT_HI
    req = 4'b0010;
    push(1);
    wait_issue(1'b0);
    sidle = 1'b0;
    tick();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("midrst_busy",    32'(busy),     32'd0);
    chk("midrst_xfer",    32'(xfer_cnt), 32'd0);
    chk("midrst_grant",   32'(grant),    32'd0);
    chk("midrst_last_id", 32'(last_id),  32'd3);
    chk("midrst_sready",  32'(sready),   32'd0);
    rst_n   = 1'b1;
    sidle   = 1'b1;
    exp_cnt = '0;

    // all requesters held: 0,1,2,3,0,1,2,3
    req = 4'b1111;
    for (int t = 0; t < 8; t++) push(t % N);
    for (int t = 0; t < 8; t++) begin
      wait_issue(1'b1);
      complete(2);
    end
    req = '0;
    chk("all_xfer8", 32'(xfer_cnt), 32'd8);

    // busy synchronizer blocks arbitration
    sidle = 1'b0;
    req   = 4'b0001;
    repeat (5) begin
      tick();
      chk("blocked_sready", 32'(sready), 32'd0);
      chk("blocked_busy",   32'(busy),   32'd0);
    end
    push(0);
    sidle = 1'b1;
    tick();
    chk("release_latency", 32'(sready), 32'd1);
    wait_issue(1'b0);
    complete(1);

    // lost start: sidle never drops after ISSUE
    req = 4'b0100;
    push(2);
    wait_issue(1'b0);
    repeat (3) begin
      tick();
      chk("lost_busy_hold", 32'(busy), 32'd1);
    end
    tick();
    chk("lost_busy_done", 32'(busy),     32'd0);
    chk("lost_xfer_same", 32'(xfer_cnt), 32'(exp_cnt));

    // counter wrap
    force dut.xfer_cnt = 16'hFFFF;
    tick();
    release dut.xfer_cnt;
    tick();
    chk("preload", 32'(xfer_cnt), 32'h0000FFFF);
    exp_cnt = 16'hFFFF;
    req = 4'b1000;
    push(3);
    wait_issue(1'b0);
    complete(1);
    chk("wrap_zero", 32'(xfer_cnt), 32'd0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
